// File: rtl/rsa_adder_pkg.sv
// Shared types and sizing helpers for the multi-precision adder.
// Default-configuration derived sizes are exported for reference.
package rsa_adder_pkg;

    function automatic int unsigned ceil_div(input int unsigned n, input int unsigned d);
        return (n + d - 1) / d;
    endfunction

    localparam int unsigned WIDTH_DEF         = 514;
    localparam int unsigned LIMB_W_DEF        = 52;
    localparam int unsigned LIMBS_PER_CYC_DEF = 5;
    localparam int unsigned NLIMBS = ceil_div(WIDTH_DEF, LIMB_W_DEF);
    localparam int unsigned NCYC   = ceil_div(NLIMBS, LIMBS_PER_CYC_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } adder_state_e;

endpackage

// File: rtl/rsa_mp_adder_if.sv
// start/busy/done handshake plus operand and result buses of the
// multi-precision adder.
interface rsa_mp_adder_if #(
    parameter int unsigned WIDTH = 514
);
    logic             start;
    logic             subtract;
    logic             shift;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             busy;
    logic             done;
    logic [WIDTH:0]   result;
    logic             carry;

    modport master (
        output start, subtract, shift, in_a, in_b,
        input  busy, done, result, carry
    );

    modport slave (
        input  start, subtract, shift, in_a, in_b,
        output busy, done, result, carry
    );
endinterface

// File: rtl/csel_limb_group.sv
// One chunk of carry-select limbs: each limb precomputes +0/+1 sums and the
// rippling limb carry only drives the select muxes.
module csel_limb_group #(
    parameter int unsigned LIMB_W        = 52,
    parameter int unsigned LIMBS_PER_CYC = 5
) (
    input  logic [LIMB_W*LIMBS_PER_CYC-1:0] a,
    input  logic [LIMB_W*LIMBS_PER_CYC-1:0] b,
    input  logic                            cin,
    output logic [LIMB_W*LIMBS_PER_CYC-1:0] sum,
    output logic                            cout
);
    localparam logic [LIMB_W:0] ONE = 1;

    logic [LIMB_W:0] s0;
    logic [LIMB_W:0] s1;
    logic            c;

    always_comb begin
        sum = '0;
        s0  = '0;
        s1  = '0;
        c   = cin;
        for (int unsigned i = 0; i < LIMBS_PER_CYC; i++) begin
            s0 = {1'b0, a[i*LIMB_W +: LIMB_W]} + {1'b0, b[i*LIMB_W +: LIMB_W]};
            s1 = {1'b0, a[i*LIMB_W +: LIMB_W]} + {1'b0, b[i*LIMB_W +: LIMB_W]} + ONE;
            sum[i*LIMB_W +: LIMB_W] = c ? s1[LIMB_W-1:0] : s0[LIMB_W-1:0];
            c = c ? s1[LIMB_W] : s0[LIMB_W];
        end
        cout = c;
    end

endmodule

// File: rtl/rsa_mp_adder.sv
// Multi-cycle multi-precision add/subtract with optional right shift; one
// carry-select chunk resolved per clock with the chunk carry registered.
module rsa_mp_adder
    import rsa_adder_pkg::*;
#(
    parameter int unsigned WIDTH         = 514,
    parameter int unsigned LIMB_W        = 52,
    parameter int unsigned LIMBS_PER_CYC = 5
) (
    input  logic          clk,
    input  logic          resetn,
    rsa_mp_adder_if.slave bus
);
    localparam int unsigned NLIMBS  = ceil_div(WIDTH, LIMB_W);
    localparam int unsigned NCYC    = ceil_div(NLIMBS, LIMBS_PER_CYC);
    localparam int unsigned CHUNK_W = LIMB_W * LIMBS_PER_CYC;
    localparam int unsigned PAD_W   = NCYC * CHUNK_W;
    localparam int unsigned CNT_W   = (NCYC > 1) ? $clog2(NCYC) : 1;

    adder_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PAD_W-1:0] a_q, a_d;
    logic [PAD_W-1:0] b_q, b_d;
    logic [PAD_W-1:0] sum_q, sum_d;
    logic             sub_q, sub_d;
    logic             shift_q, shift_d;
    logic             cin_q, cin_d;
    logic [WIDTH:0]   result_q, result_d;
    logic             carry_q, carry_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [CHUNK_W-1:0] grp_a, grp_b, grp_sum;
    logic               grp_cout;
    logic [WIDTH-1:0]   b_sel;
    logic [PAD_W:0]     sum_x;
    logic               unused_pad;

    csel_limb_group #(
        .LIMB_W       (LIMB_W),
        .LIMBS_PER_CYC(LIMBS_PER_CYC)
    ) u_group (
        .a   (grp_a),
        .b   (grp_b),
        .cin (cin_q),
        .sum (grp_sum),
        .cout(grp_cout)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_d    = sum_q;
        sub_d    = sub_q;
        shift_d  = shift_q;
        cin_d    = cin_q;
        result_d = result_q;
        carry_d  = carry_q;
        b_sel    = '0;
        grp_a    = '0;
        grp_b    = '0;

        // Single adder instance; the chunk under work is muxed in by cnt.
        for (int unsigned i = 0; i < NCYC; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                grp_a = a_q[i*CHUNK_W +: CHUNK_W];
                grp_b = b_q[i*CHUNK_W +: CHUNK_W];
            end
        end

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    b_sel   = bus.subtract ? ~bus.in_b : bus.in_b;
                    a_d     = PAD_W'(bus.in_a);
                    b_d     = PAD_W'(b_sel);
                    sub_d   = bus.subtract;
                    shift_d = bus.shift;
                    cin_d   = bus.subtract;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int unsigned i = 0; i < NCYC; i++) begin
                    if (cnt_q == CNT_W'(i)) begin
                        sum_d[i*CHUNK_W +: CHUNK_W] = grp_sum;
                    end
                end
                cin_d = grp_cout;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(NCYC - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    carry_d = sum_x[WIDTH];
                    if (shift_q) begin
                        result_d = {1'b0, sum_x[WIDTH] ^ sub_q, sum_d[WIDTH-1:1]};
                    end else begin
                        result_d = {sum_x[WIDTH] ^ sub_q, sum_d[WIDTH-1:0]};
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // Zero-padded operands push the carry out of bit WIDTH-1 into bit WIDTH,
    // which lands in the final chunk cout when padding is exactly zero.
    assign sum_x      = {grp_cout, sum_d};
    assign unused_pad = ^sum_x;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            sub_q    <= 1'b0;
            shift_q  <= 1'b0;
            cin_q    <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sum_q    <= sum_d;
            sub_q    <= sub_d;
            shift_q  <= shift_d;
            cin_q    <= cin_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.carry  = carry_q;

endmodule

// File: tb/tb_rsa_mp_adder.sv
// Scoreboard bench for rsa_mp_adder: default 514-bit build (NCYC=2) and a
// 64-bit single-cycle build, both checked against an arithmetic model.
module tb_rsa_mp_adder;
    localparam int unsigned WB     = 514;
    localparam int unsigned WS     = 64;
    localparam int unsigned NCYC_B = 2;
    localparam int unsigned NCYC_S = 1;

    typedef logic [WB+1:0] wide_t;
    typedef struct {
        wide_t  res;
        logic   c;
        longint edge_no;
    } exp_t;

    logic   clk    = 1'b0;
    logic   resetn = 1'b0;
    longint cyc    = 0;
    int     tests  = 0;
    int     fails  = 0;
    exp_t   q_big[$];
    exp_t   q_sml[$];
    wide_t  last_big = '0;
    wide_t  hold_big = '0;
    wide_t  one      = 1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rsa_mp_adder_if #(.WIDTH(WB)) bus_big ();
    rsa_mp_adder_if #(.WIDTH(WS)) bus_sml ();

    rsa_mp_adder #(.WIDTH(WB), .LIMB_W(52), .LIMBS_PER_CYC(5)) dut_big (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus_big)
    );

    rsa_mp_adder #(.WIDTH(WS), .LIMB_W(16), .LIMBS_PER_CYC(4)) dut_sml (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus_sml)
    );

    function void check(input string name, input wide_t act, input wide_t req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endfunction

    // Reference: plain integer arithmetic; for subtraction the flag bit is a<b.
    function automatic void ref_op(input wide_t a, input wide_t b, input bit sub, input bit sh,
                                   input int unsigned w, output wide_t res, output logic c);
        wide_t mask;
        wide_t s;
        bit    msb;
        mask = (wide_t'(1) << w) - 1;
        if (sub) begin
            c   = (a >= b);
            msb = (a < b);
            s   = (a - b) & mask;
        end else begin
            s   = a + b;
            c   = s[w];
            msb = c;
            s   = s & mask;
        end
        if (sh) res = (wide_t'(msb) << (w - 1)) | (s >> 1);
        else    res = (wide_t'(msb) << w) | s;
    endfunction

    function automatic wide_t rand_op(input int unsigned w);
        wide_t v = '0;
        wide_t mask;
        mask = (wide_t'(1) << w) - 1;
        for (int i = 0; i < 17; i++) v = (v << 32) | wide_t'($urandom);
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return mask;
            2:       return wide_t'(1);
            default: return v & mask;
        endcase
    endfunction

    // Scoreboard monitors: pop one expectation per done pulse.
    always @(negedge clk) begin
        if (resetn && bus_big.done) begin
            if (q_big.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL big_unexpected_done: got done=1, required done=0");
            end else begin : pop_big
                exp_t e;
                e = q_big.pop_front();
                check("big_result", wide_t'(bus_big.result), e.res);
                check("big_carry", wide_t'(bus_big.carry), wide_t'(e.c));
                check("big_latency", wide_t'(cyc - e.edge_no), wide_t'(NCYC_B));
            end
        end
    end

    always @(negedge clk) begin
        if (resetn && bus_sml.done) begin
            if (q_sml.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sml_unexpected_done: got done=1, required done=0");
            end else begin : pop_sml
                exp_t e;
                e = q_sml.pop_front();
                check("sml_result", wide_t'(bus_sml.result), e.res);
                check("sml_carry", wide_t'(bus_sml.carry), wide_t'(e.c));
                check("sml_latency", wide_t'(cyc - e.edge_no), wide_t'(NCYC_S));
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push_op(input bit big, input wide_t a, input wide_t b, input bit sub,
                           input bit sh, input wide_t er, input logic ec);
        int   n = 0;
        exp_t e;
        while ((big ? bus_big.busy : bus_sml.busy) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            tests++;
            fails++;
            $display("FAIL %s_idle_timeout: got busy=1, required busy=0", big ? "big" : "sml");
        end
        e.res     = er;
        e.c       = ec;
        e.edge_no = cyc + 1;
        if (big) begin
            bus_big.in_a     = a[WB-1:0];
            bus_big.in_b     = b[WB-1:0];
            bus_big.subtract = sub;
            bus_big.shift    = sh;
            bus_big.start    = 1'b1;
            hold_big         = last_big;
            last_big         = er;
            q_big.push_back(e);
        end else begin
            bus_sml.in_a     = a[WS-1:0];
            bus_sml.in_b     = b[WS-1:0];
            bus_sml.subtract = sub;
            bus_sml.shift    = sh;
            bus_sml.start    = 1'b1;
            q_sml.push_back(e);
        end
        @(negedge clk);
        bus_big.start = 1'b0;
        bus_sml.start = 1'b0;
    endtask

    task automatic issue(input bit big, input wide_t a, input wide_t b, input bit sub, input bit sh);
        wide_t r;
        logic  c;
        ref_op(a, b, sub, sh, big ? WB : WS, r, c);
        push_op(big, a, b, sub, sh, r, c);
    endtask

    task automatic issue_rand(input bit big);
        wide_t a, b;
        a = rand_op(big ? WB : WS);
        b = ($urandom_range(0, 5) == 0) ? a : rand_op(big ? WB : WS);
        issue(big, a, b, 1'($urandom), 1'($urandom));
    endtask

    task automatic wait_done(input bit big, output longint at);
        int n = 0;
        while (!(big ? bus_big.done : bus_sml.done) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            tests++;
            fails++;
            $display("FAIL %s_done_timeout: got done=0, required done=1", big ? "big" : "sml");
        end
        at = cyc;
    endtask

    task automatic drain();
        int n = 0;
        while ((q_big.size() != 0 || q_sml.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("big_queue_empty", wide_t'(q_big.size()), '0);
        check("sml_queue_empty", wide_t'(q_sml.size()), '0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        longint t1, t2;
        bus_big.start = 1'b0; bus_big.subtract = 1'b0; bus_big.shift = 1'b0;
        bus_big.in_a  = '0;   bus_big.in_b     = '0;
        bus_sml.start = 1'b0; bus_sml.subtract = 1'b0; bus_sml.shift = 1'b0;
        bus_sml.in_a  = '0;   bus_sml.in_b     = '0;

        repeat (3) @(negedge clk);
        check("rst_busy", wide_t'(bus_big.busy), '0);
        check("rst_done", wide_t'(bus_big.done), '0);
        check("rst_result", wide_t'(bus_big.result), '0);
        check("rst_carry", wide_t'(bus_big.carry), '0);
        check("rst_sml_result", wide_t'(bus_sml.result), '0);
        resetn = 1'b1;
        @(negedge clk);

        push_op(1, 1, 1, 0, 0, 2, 1'b0);
        push_op(1, 5, 7, 1, 0, (one << 515) - 2, 1'b0);
        push_op(1, 7, 5, 1, 0, 2, 1'b1);
        push_op(1, (one << 260) - 1, 1, 0, 0, one << 260, 1'b0);
        push_op(1, (one << 514) - 1, 1, 0, 1, one << 513, 1'b1);

        // start during RUN must be ignored and the previous result held
        issue_rand(1);
        bus_big.in_a     = rand_op(WB);
        bus_big.subtract = ~bus_big.subtract;
        bus_big.start    = 1'b1;
        check("big_busy_in_run", wide_t'(bus_big.busy), wide_t'(1));
        check("big_result_held", wide_t'(bus_big.result), hold_big);
        @(negedge clk);
        bus_big.start = 1'b0;
        check("big_result_held2", wide_t'(bus_big.result), hold_big);

        // start accepted in the DONE cycle: one result every NCYC+1 cycles
        wait_done(1, t1);
        issue_rand(1);
        wait_done(1, t2);
        check("big_b2b_spacing", wide_t'(t2 - t1), wide_t'(NCYC_B + 1));

        for (int i = 0; i < 30; i++) begin
            int gap = $urandom_range(0, 3);
            if (gap == 3 && bus_big.busy) wait_done(1, t1);
            else repeat (gap) @(negedge clk);
            issue_rand(1);
        end
        drain();

        // reset one cycle after start: no done, outputs back to reset values
        bus_big.in_a  = rand_op(WB);
        bus_big.in_b  = rand_op(WB);
        bus_big.start = 1'b1;
        @(negedge clk);
        bus_big.start = 1'b0;
        resetn        = 1'b0;
        @(negedge clk);
        check("midrst_busy", wide_t'(bus_big.busy), '0);
        check("midrst_done", wide_t'(bus_big.done), '0);
        check("midrst_result", wide_t'(bus_big.result), '0);
        check("midrst_carry", wide_t'(bus_big.carry), '0);
        resetn = 1'b1;
        last_big = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("midrst_no_done", wide_t'(bus_big.done), '0);
        end

        push_op(0, (one << 64) - 1, 1, 0, 0, one << 64, 1'b1);
        push_op(0, 3, 9, 1, 1, (one << 63) | (((one << 64) - 6) >> 1), 1'b0);
        for (int i = 0; i < 25; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue_rand(0);
        end
        issue_rand(1);
        issue_rand(1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
